// File: rtl/reg_share_pkg.sv
// rtl/reg_share_pkg.sv - shared types, defaults and width helper for the register-share arbiter
package reg_share_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 8;
  localparam int HOLD_MAX_DEF = 4;

  // Bits needed to index 'count' items; never narrower than one bit.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int PTR_W_DEF = width_of(N_DEF);

endpackage

// File: rtl/reg_share_arbiter_rr_picker.sv
// rtl/reg_share_arbiter_rr_picker.sv - combinational round-robin winner search starting at ptr
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] winner_o,
  output logic          any_valid_o
);

  // Walk from ptr upward with wrap; the first set bit wins.
  always_comb begin
    int idx;
    winner_o    = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any_valid_o && req_i[idx]) begin
        any_valid_o = 1'b1;
        winner_o    = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin arbiter with bounded lock in front of one shared register
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  localparam int PW      = width_of(N),
  localparam int CW      = width_of(HOLD_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   Q,
  output logic [PW-1:0]  owner,
  output logic           valid,
  output logic           timeout
);

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  eff;
  logic [PW-1:0] win;
  logic          any_win;
  logic          lock_owner;
  logic          req_owner;
  logic          cnt_last;
  logic          lock_exit;

  // A requester being acked this cycle is masked so its served request is not granted twice.
  assign eff = req & ~ack_q;

  rr_picker #(
    .N  (N),
    .PW (PW)
  ) u_picker (
    .req_i       (eff),
    .ptr_i       (ptr_q),
    .winner_o    (win),
    .any_valid_o (any_win)
  );

  assign lock_owner = lock[owner_q];
  assign req_owner  = req[owner_q];
  assign cnt_last   = (cnt_q == CW'(HOLD_MAX - 1));
  assign lock_exit  = !lock_owner || cnt_last;

  // State register; reset wins over an active lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter LOCKED on a locked grant, leave on release or hold expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_win && lock[win]) state_d = LOCKED;
      LOCKED:  if (lock_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; ack and timeout default to idle so they only pulse.
  always_comb begin
    q_d       = q_q;
    ack_d     = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_win) begin
          q_d     = wdata[win*W +: W];
          ack_d   = {{(N-1){1'b0}}, 1'b1} << win;
          owner_d = win;
          valid_d = 1'b1;
          ptr_d   = (win == PW'(N - 1)) ? '0 : win + 1'b1;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (req_owner) begin
          q_d   = wdata[owner_q*W +: W];
          ack_d = {{(N-1){1'b0}}, 1'b1} << owner_q;
        end
        if (lock_exit) begin
          cnt_d     = '0;
          // A voluntary release in the expiry cycle suppresses the timeout pulse.
          timeout_d = lock_owner && cnt_last;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Registered datapath, pointer, counter and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q       <= '0;
      ack_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      ack_q     <= ack_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign Q       = q_q;
  assign ack     = ack_q;
  assign owner   = owner_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - scoreboard bench for the register-share arbiter
module tb_reg_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int HM = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [1:0]     owner;
  logic           valid;
  logic           timeout;

  reg_share_arbiter #(.N(N), .W(W), .HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .ack     (ack),
    .Q       (q),
    .owner   (owner),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] q;
    logic [1:0] owner;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // reference state of the arbiter
  logic       m_locked;
  int         m_ptr;
  int         m_cnt;
  logic [3:0] m_ack;
  logic [7:0] m_q;
  int         m_owner;
  logic       m_valid;
  logic       m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r_n, input logic [3:0] rq, input logic [3:0] lk,
                            input logic [31:0] wd);
    logic [3:0] eff;
    int         g;
    logic       found;
    if (!r_n) begin
      m_locked = 1'b0; m_ptr = 0; m_cnt = 0; m_ack = 4'h0;
      m_q = 8'h00; m_owner = 0; m_valid = 1'b0; m_to = 1'b0;
    end else if (!m_locked) begin
      eff   = rq & ~m_ack;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && eff[(m_ptr + k) % N]) begin
          found = 1'b1;
          g     = (m_ptr + k) % N;
        end
      end
      m_to = 1'b0;
      if (found) begin
        m_q     = wd[g*8 +: 8];
        m_ack   = 4'(1 << g);
        m_owner = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % N;
        if (lk[g]) begin
          m_locked = 1'b1;
          m_cnt    = 0;
        end
      end else begin
        m_ack = 4'h0;
      end
    end else begin
      if (rq[m_owner]) begin
        m_q   = wd[m_owner*8 +: 8];
        m_ack = 4'(1 << m_owner);
      end else begin
        m_ack = 4'h0;
      end
      if (!lk[m_owner]) begin
        m_locked = 1'b0; m_cnt = 0; m_to = 1'b0;
      end else if (m_cnt == HM - 1) begin
        m_locked = 1'b0; m_cnt = 0; m_to = 1'b1;
      end else begin
        m_cnt = m_cnt + 1; m_to = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r_n, input logic [3:0] rq, input logic [3:0] lk,
                      input logic [31:0] wd);
    exp_t e;
    exp_t got;
    rst_n = r_n;
    req   = rq;
    lock  = lk;
    wdata = wd;
    model_edge(r_n, rq, lk, wd);
    e.ack = m_ack; e.q = m_q; e.owner = 2'(m_owner); e.valid = m_valid; e.to = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_ack", 32'(ack), 32'(got.ack));
    check("sb_q", 32'(q), 32'(got.q));
    check("sb_owner", 32'(owner), 32'(got.owner));
    check("sb_valid", 32'(valid), 32'(got.valid));
    check("sb_timeout", 32'(timeout), 32'(got.to));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic [3:0]  exp_seq [5];
    rst_n = 1'b0; req = '0; lock = '0; wdata = '0;

    // reset for two edges
    step(0, 4'h0, 4'h0, 32'h0);
    step(0, 4'hF, 4'hF, 32'hFFFF_FFFF);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // all four requesting: 0,1,2,3,0
    wd = 32'h4433_2211;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(1, 4'hF, 4'h0, wd);
      check("rr_order", 32'(ack), 32'(exp_seq[i]));
    end
    step(1, 4'h0, 4'h0, wd);

    // single continuous requester is acked every other cycle
    for (int i = 0; i < 6; i++) begin
      step(1, 4'b0100, 4'h0, 32'h00A5_0000);
      check("mask_ack", 32'(ack), (i % 2 == 0) ? 32'h4 : 32'h0);
    end
    check("mask_q", 32'(q), 32'hA5);

    // pointer wrap 3 -> 0 -> 3
    step(0, 4'h0, 4'h0, 32'h0);
    step(1, 4'b0100, 4'h0, 32'h0);
    step(1, 4'b0000, 4'h0, 32'h0);
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b1001, 4'h0, 32'hD000_00C0);
      check("wrap_ack", 32'(ack), 32'(exp_seq[i]));
    end

    // lock held 3 cycles then released, requester 0 waits
    step(0, 4'h0, 4'h0, 32'h0);
    step(1, 4'b0001, 4'h0, 32'h0);
    step(1, 4'b0000, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'b0011, (i < 3) ? 4'b0010 : 4'b0000, {16'h0, 8'(8'h60 + i), 8'h0F});
      check("rel_ack", 32'(ack), 32'h2);
      check("rel_q", 32'(q), 32'(8'h60 + i));
      check("rel_to", 32'(timeout), 32'h0);
    end
    step(1, 4'b0001, 4'h0, 32'h0000_0077);
    check("rel_next", 32'(ack), 32'h1);
    check("rel_owner", 32'(owner), 32'h0);

    // lock held through expiry: five writes then timeout
    step(0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b1100, 4'b0100, {8'h33, 8'(8'h80 + i), 16'h0});
      check("to_ack", 32'(ack), 32'h4);
      check("to_pulse", 32'(timeout), (i == 4) ? 32'h1 : 32'h0);
    end
    step(1, 4'b1100, 4'b0100, 32'h3300_0000);
    check("to_next", 32'(ack), 32'h8);
    check("to_clear", 32'(timeout), 32'h0);

    // release coincides with expiry: no timeout
    step(0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b1100, (i == 4) ? 4'b0000 : 4'b0100, 32'h3391_0000);
      check("both_ack", 32'(ack), 32'h4);
      check("both_to", 32'(timeout), 32'h0);
    end
    step(1, 4'b1100, 4'b0000, 32'h3391_0000);
    check("both_next", 32'(ack), 32'h8);

    // reset during lock
    step(0, 4'h0, 4'h0, 32'h0);
    step(1, 4'b0010, 4'b0010, 32'h0000_5500);
    step(1, 4'b0010, 4'b0010, 32'h0000_5500);
    step(0, 4'b0010, 4'b0010, 32'h0000_5500);
    check("mid_ack", 32'(ack), 32'h0);
    check("mid_q", 32'(q), 32'h0);
    check("mid_valid", 32'(valid), 32'h0);
    step(1, 4'hF, 4'h0, 32'h0403_0201);
    check("mid_ptr", 32'(ack), 32'h1);

    // random traffic against the reference
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 29) != 0), 4'($urandom), 4'(($urandom_range(0, 2) == 0) ? $urandom : 0),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one W-bit D-flip-flop register among N requesters. Each requester presents write data with a request. The arbiter picks one winner per cycle, loads the register, and returns a one-cycle acknowledge. A requester may also lock the register for a bounded burst of back-to-back writes. The block sits in front of the flip-flop storage in the flipflop area and is the only path by which that storage is written.

## Interface
Parameters:
- N, 4, number of requesters (≥2)
- W, 8, register width
- HOLD_MAX, 4, maximum number of cycles spent in LOCKED before a forced release (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  N  write request, one bit per requester
- lock  input  N  lock request; sampled only at grant time and while in LOCKED
- wdata  input  N*W  requester i's data in bits [i*W +: W]
- ack  output  N  one-hot, one-cycle pulse: requester's write was committed
- Q  output  W  register contents
- owner  output  clog2(N)  index of the last granted requester
- valid  output  1  Q has been written at least once since reset
- timeout  output  1  one-cycle pulse: lock was forcibly released

## Operation
- Reset (rst_n=0 at a rising edge) is synchronous and active-low; it overrides every other event, including an active lock. Reset values: Q=0, ack=0, owner=0, valid=0, timeout=0, rr pointer ptr=0, state=IDLE, hold counter cnt=0.
- **IDLE** state:
  - Effective request: eff[i] = req[i] & ~ack[i]. A requester whose ack is high this cycle is masked, so it is not re-granted for the request just served.
  - Winner g: the first set bit of eff, searching from ptr upward and wrapping past N-1 to 0.
  - At the edge: Q<=wdata[g], ack<=onehot(g), owner<=g, valid<=1, ptr<=(g+1) mod N.
  - If lock[g]=1 at that edge, the next state is LOCKED and cnt<=0. No effective request means no change and ack<=0.
- **LOCKED** state:
  - Only the owner is served; all other req bits are ignored.
  - Each cycle with req[owner]=1: Q<=wdata[owner] and ack[owner]<=1. There is no ack masking in this state, so back-to-back writes are allowed.
  - cnt increments every LOCKED cycle.
  - Exit to IDLE when lock[owner]=0; that cycle's write is still honored.
  - Also exit to IDLE when cnt==HOLD_MAX-1. On this forced exit, timeout<=1 for one cycle, and the write in that cycle is still honored.
  - If both exit conditions hold in the same cycle, exit without a timeout pulse.
  - On any exit, ptr stays at owner+1.
- Arithmetic rules:
  - ptr and owner wrap modulo N.
  - cnt is clog2(HOLD_MAX+1) bits wide and never exceeds HOLD_MAX-1.

## Timing
- Latency: a request sampled at edge k produces ack, Q and owner updates visible after edge k, i.e. in cycle k+1. All outputs are registered.
- Handshake: requesters hold req and wdata stable until they see ack. ack is high in the cycle after the commit. A requester that is still asserting req during its own ack cycle is treated as issuing a new request, which can be granted no earlier than the following edge.
- Throughput:
  - IDLE: one write per cycle overall, and at most one write per requester every 2 cycles.
  - LOCKED: one write per cycle for the owner.
- Lock duration: the grant cycle plus at most HOLD_MAX LOCKED cycles, so at most HOLD_MAX+1 consecutive owner writes.
- Reset asserted mid-lock: the state is IDLE, ptr=0 and all outputs are cleared after that edge.

## Structure
- Package reg_share_pkg holds:
  - the state enum {IDLE, LOCKED}
  - a width helper localparam pattern for clog2(N)
  - the default values of N, W and HOLD_MAX
- Sub-module rr_picker: purely combinational. Inputs are an N-bit request vector and ptr. Outputs are winner index and any_valid. It is reused by the future read-port arbiter.
- Top level: FSM, cnt, ptr, Q register and output registers.

## Test plan
- Reset: with rst_n=0 for 2 edges → Q=0, ack=0, valid=0, owner=0, timeout=0. Then with req=4'b1111 → grants in order 0,1,2,3,0, each ack lasting one cycle.
- Masking: only requester 2 holds req=1 continuously with wdata=8'hA5 → ack[2] pulses every other cycle and Q=8'hA5.
- Wrap: ptr=3 and req=4'b1001 → requester 3 is granted, then requester 0, then 3.
- Lock release: requester 1 with lock=1 and req=1 for 3 cycles, then lock=0, while req[0] stays high → requester 1 is acked on 4 consecutive cycles, requester 0 is blocked, timeout stays 0, then requester 0 is granted with ptr at 2.
- Lock timeout: HOLD_MAX=4, lock[2] held high → 5 consecutive acks to requester 2, timeout pulses once in the cycle after the 5th write edge, then the next requester (3 or 0) is granted. Also drop lock in the same cycle cnt=3 → no timeout pulse.
- Reset mid-lock: rst_n=0 during LOCKED → all outputs and ptr return to zero on that edge, and no ack is issued.
